// File: rtl/rv_writeback_if.sv
// Execute/memory/register-file signal bundle for the uRV writeback stage.
// w_misaligned_o exists only when URV_WB_MISALIGN_CHECK_EN is defined; w_state_o exposes the FSM (IDLE=0).
interface rv_writeback_if;
    logic [2:0]  x_fun_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i;
    logic        x_rd_write_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    logic        rf_rd_write_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        w_stall_req_o;
    logic [1:0]  w_state_o;
`ifdef URV_WB_MISALIGN_CHECK_EN
    logic        w_misaligned_o;
`endif

    // Handshake: a load/store strobe is accepted in IDLE; the access completes on the
    // cycle its dm_*_done_i is high, and the stage stalls upstream until then.
    modport slave (
        input  x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_value_i, x_rd_write_i,
        input  x_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
        output rf_rd_write_o, rf_rd_o, rf_rd_value_o, w_stall_req_o, w_state_o
`ifdef URV_WB_MISALIGN_CHECK_EN
        , output w_misaligned_o
`endif
    );

    modport master (
        output x_fun_i, x_load_i, x_store_i, x_rd_i, x_rd_value_i, x_rd_write_i,
        output x_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
        input  rf_rd_write_o, rf_rd_o, rf_rd_value_o, w_stall_req_o, w_state_o
`ifdef URV_WB_MISALIGN_CHECK_EN
        , input w_misaligned_o
`endif
    );
endinterface

// File: rtl/rv_writeback.sv
// uRV writeback stage: completes loads/stores, aligns load data, drives the register-file write port.
// Optional feature: URV_WB_MISALIGN_CHECK_EN suppresses misaligned LH/LHU/LW writes and flags them.
module rv_writeback (
    input logic clk_i,
    input logic rst_i,
    rv_writeback_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_LOAD  = 2'd1,
        WAIT_STORE = 2'd2
    } state_e;

    state_e      state_q;
    logic [4:0]  rd_q;
    logic [2:0]  fun_q;
    logic [1:0]  addr_q;
    logic        rf_rd_write_q;
    logic [4:0]  rf_rd_q;
    logic [31:0] rf_rd_value_q;

    logic [2:0]  ld_fun;
    logic [1:0]  ld_addr;
    logic [4:0]  ld_rd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_value;
    logic        ld_ok;
    logic        ld_wr_en;
    logic        ld_done;
    logic        alu_wr;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.x_dm_addr_i[31:2];

    // In IDLE a zero-wait load completes straight from the execute inputs.
    always_comb begin
        ld_fun  = fun_q;
        ld_addr = addr_q;
        ld_rd   = rd_q;
        if (state_q == IDLE) begin
            ld_fun  = bus.x_fun_i;
            ld_addr = bus.x_dm_addr_i[1:0];
            ld_rd   = bus.x_rd_i;
        end
        case (ld_addr)
            2'd0:    byte_sel = bus.dm_data_l_i[7:0];
            2'd1:    byte_sel = bus.dm_data_l_i[15:8];
            2'd2:    byte_sel = bus.dm_data_l_i[23:16];
            default: byte_sel = bus.dm_data_l_i[31:24];
        endcase
        half_sel = ld_addr[1] ? bus.dm_data_l_i[31:16] : bus.dm_data_l_i[15:0];
        ld_value = 32'd0;
        ld_ok    = 1'b1;
        case (ld_fun)
            3'b000:  ld_value = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_value = {24'd0, byte_sel};
            3'b001:  ld_value = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_value = {16'd0, half_sel};
            3'b010:  ld_value = bus.dm_data_l_i;
            default: ld_ok    = 1'b0;
        endcase
    end

`ifdef URV_WB_MISALIGN_CHECK_EN
    logic ld_mis;
    logic mis_q;

    always_comb begin
        ld_mis = 1'b0;
        case (ld_fun)
            3'b001, 3'b101: ld_mis = ld_addr[0];
            3'b010:         ld_mis = (ld_addr != 2'd0);
            default:        ld_mis = 1'b0;
        endcase
    end

    assign ld_wr_en = ld_ok & ~ld_mis & (ld_rd != 5'd0);
    assign bus.w_misaligned_o = mis_q;
`else
    assign ld_wr_en = ld_ok & (ld_rd != 5'd0);
`endif

    assign ld_done = bus.dm_load_done_i &
                     (((state_q == IDLE) & bus.x_load_i) | (state_q == WAIT_LOAD));
    assign alu_wr  = (state_q == IDLE) & ~bus.x_load_i & bus.x_rd_write_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rd_q          <= 5'd0;
            fun_q         <= 3'd0;
            addr_q        <= 2'd0;
            rf_rd_write_q <= 1'b0;
            rf_rd_q       <= 5'd0;
            rf_rd_value_q <= 32'd0;
`ifdef URV_WB_MISALIGN_CHECK_EN
            mis_q         <= 1'b0;
`endif
        end else begin
            rf_rd_write_q <= 1'b0;
`ifdef URV_WB_MISALIGN_CHECK_EN
            mis_q         <= 1'b0;
`endif
            if (ld_done) begin
                rf_rd_write_q <= ld_wr_en;
                rf_rd_q       <= ld_rd;
                rf_rd_value_q <= ld_value;
`ifdef URV_WB_MISALIGN_CHECK_EN
                mis_q         <= ld_mis;
`endif
            end else if (alu_wr) begin
                rf_rd_write_q <= (bus.x_rd_i != 5'd0);
                rf_rd_q       <= bus.x_rd_i;
                rf_rd_value_q <= bus.x_rd_value_i;
            end
            case (state_q)
                IDLE: begin
                    if (bus.x_load_i) begin
                        if (!bus.dm_load_done_i) begin
                            state_q <= WAIT_LOAD;
                            rd_q    <= bus.x_rd_i;
                            fun_q   <= bus.x_fun_i;
                            addr_q  <= bus.x_dm_addr_i[1:0];
                        end
                    end else if (bus.x_store_i && !bus.dm_store_done_i) begin
                        state_q <= WAIT_STORE;
                    end
                end
                WAIT_LOAD:  if (bus.dm_load_done_i) state_q <= IDLE;
                WAIT_STORE: if (bus.dm_store_done_i) state_q <= IDLE;
                default:    state_q <= IDLE;
            endcase
        end
    end

    // Stall drops in the same cycle the completing done arrives.
    assign bus.w_stall_req_o =
        ((state_q == WAIT_LOAD)  & ~bus.dm_load_done_i) |
        ((state_q == WAIT_STORE) & ~bus.dm_store_done_i) |
        ((state_q == IDLE) & ((bus.x_load_i & ~bus.dm_load_done_i) |
                              (~bus.x_load_i & bus.x_store_i & ~bus.dm_store_done_i)));

    assign bus.rf_rd_write_o = rf_rd_write_q;
    assign bus.rf_rd_o       = rf_rd_q;
    assign bus.rf_rd_value_o = rf_rd_value_q;
    assign bus.w_state_o     = state_q;
endmodule

// File: tb/tb_rv_writeback.sv
// Directed plus randomized bench for rv_writeback against a transaction-level load/store model.
module tb_rv_writeback;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rv_writeback_if bus ();

    rv_writeback dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(bus.x_load_i && bus.x_store_i))
        else begin
            errors++;
            $error("FAIL illegal_strobes: observed load=1 store=1 required not both");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.x_load_i        = 1'b0;
        bus.x_store_i       = 1'b0;
        bus.x_rd_write_i    = 1'b0;
        bus.dm_load_done_i  = 1'b0;
        bus.dm_store_done_i = 1'b0;
    endtask

    // Expected load outcome from the ISA rules: lane by shift, extension by arithmetic.
    function automatic void model(input logic [2:0] fun, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [4:0] rd,
                                  output logic [31:0] v, output logic w, output logic mis);
        logic [31:0] b;
        logic [31:0] h;
        b   = (data >> (8 * addr[1:0])) & 32'hFF;
        h   = (data >> (16 * addr[1])) & 32'hFFFF;
        w   = 1'b1;
        mis = 1'b0;
        case (fun)
            3'd0: v = (b >= 128) ? b - 32'd256 : b;
            3'd4: v = b;
            3'd1: begin v = (h >= 32768) ? h - 32'd65536 : h; mis = addr[0]; end
            3'd5: begin v = h; mis = addr[0]; end
            3'd2: begin v = data; mis = (addr[1:0] != 2'd0); end
            default: begin v = 32'd0; w = 1'b0; end
        endcase
`ifdef URV_WB_MISALIGN_CHECK_EN
        if (mis) w = 1'b0;
`else
        mis = 1'b0;
`endif
        if (rd == 5'd0) w = 1'b0;
    endfunction

    task automatic tx_load(input logic [2:0] fun, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input int lat);
        logic [31:0] exp_v;
        logic        exp_w;
        logic        exp_mis;
        model(fun, addr, data, rd, exp_v, exp_w, exp_mis);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) begin
                bus.x_load_i     = 1'b1;
                bus.x_fun_i      = fun;
                bus.x_dm_addr_i  = addr;
                bus.x_rd_i       = rd;
                bus.x_rd_value_i = $urandom;
            end else begin
                bus.x_fun_i      = 3'($urandom);
                bus.x_dm_addr_i  = $urandom;
                bus.x_rd_i       = 5'($urandom);
                bus.x_rd_value_i = $urandom;
                case ($urandom_range(0, 3))
                    0: bus.x_load_i     = 1'b1;
                    1: bus.x_store_i    = 1'b1;
                    2: bus.x_rd_write_i = 1'b1;
                    default: ;
                endcase
            end
            bus.dm_load_done_i = (c == lat);
            bus.dm_data_l_i    = (c == lat) ? data : $urandom;
            #1;
            chk("ld_stall", 32'(bus.w_stall_req_o), 32'(c != lat));
            chk("ld_no_early_write", 32'(bus.rf_rd_write_o), 32'd0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("ld_write", 32'(bus.rf_rd_write_o), 32'(exp_w));
        if (exp_w) begin
            chk("ld_rd", 32'(bus.rf_rd_o), 32'(rd));
            chk("ld_value", bus.rf_rd_value_o, exp_v);
        end
`ifdef URV_WB_MISALIGN_CHECK_EN
        chk("ld_misaligned", 32'(bus.w_misaligned_o), 32'(exp_mis));
`endif
        chk("ld_stall_after", 32'(bus.w_stall_req_o), 32'd0);
    endtask

    task automatic tx_store(input int lat);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            drive_idle();
            bus.x_store_i       = (c == 0);
            bus.x_dm_addr_i     = $urandom;
            bus.x_rd_i          = 5'($urandom);
            bus.dm_store_done_i = (c == lat);
            #1;
            chk("st_stall", 32'(bus.w_stall_req_o), 32'(c != lat));
            chk("st_no_write", 32'(bus.rf_rd_write_o), 32'd0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("st_write_after", 32'(bus.rf_rd_write_o), 32'd0);
        chk("st_stall_after", 32'(bus.w_stall_req_o), 32'd0);
    endtask

    task automatic tx_alu(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        drive_idle();
        bus.x_rd_write_i = 1'b1;
        bus.x_rd_i       = rd;
        bus.x_rd_value_i = val;
        #1;
        chk("alu_stall", 32'(bus.w_stall_req_o), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("alu_write", 32'(bus.rf_rd_write_o), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            chk("alu_rd", 32'(bus.rf_rd_o), 32'(rd));
            chk("alu_value", bus.rf_rd_value_o, val);
        end
    endtask

    task automatic tx_stray_done();
        @(negedge clk);
        drive_idle();
        bus.dm_load_done_i  = 1'($urandom);
        bus.dm_store_done_i = 1'($urandom);
        bus.dm_data_l_i     = $urandom;
        #1;
        chk("stray_stall", 32'(bus.w_stall_req_o), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("stray_no_write", 32'(bus.rf_rd_write_o), 32'd0);
        chk("stray_state", 32'(bus.w_state_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        bus.x_fun_i      = 3'd0;
        bus.x_rd_i       = 5'd0;
        bus.x_rd_value_i = 32'd0;
        bus.x_dm_addr_i  = 32'd0;
        bus.dm_data_l_i  = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_write", 32'(bus.rf_rd_write_o), 32'd0);
        chk("rst_rd", 32'(bus.rf_rd_o), 32'd0);
        chk("rst_value", bus.rf_rd_value_o, 32'd0);
        chk("rst_stall", 32'(bus.w_stall_req_o), 32'd0);
        chk("rst_state", 32'(bus.w_state_o), 32'd0);
`ifdef URV_WB_MISALIGN_CHECK_EN
        chk("rst_misaligned", 32'(bus.w_misaligned_o), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        tx_load(3'b000, 32'h0000_1003, 32'h80FF_0000, 5'd5, 0);
        tx_load(3'b101, 32'h0000_2002, 32'hBEEF_1234, 5'd7, 3);
        tx_alu(5'd0, 32'hDEAD_BEEF);
        tx_alu(5'd12, 32'h1234_5678);
        tx_store(2);
        tx_store(0);
        tx_load(3'b010, 32'h0000_0102, 32'hCAFE_F00D, 5'd3, 0);
        tx_load(3'b001, 32'h0000_0001, 32'h0000_8001, 5'd4, 1);
        tx_load(3'b011, 32'h0000_0000, 32'h1111_1111, 5'd6, 1);
        tx_load(3'b000, 32'h0000_0000, 32'h0000_00FF, 5'd0, 0);
        tx_stray_done();

        // Reset while a load is outstanding abandons it.
        @(negedge clk);
        drive_idle();
        bus.x_load_i    = 1'b1;
        bus.x_fun_i     = 3'b010;
        bus.x_dm_addr_i = 32'h0000_0040;
        bus.x_rd_i      = 5'd9;
        #1;
        chk("rstw_stall_issue", 32'(bus.w_stall_req_o), 32'd1);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.dm_load_done_i = 1'b1;
        bus.dm_data_l_i    = 32'hFFFF_FFFF;
        #1;
        chk("rstw_state", 32'(bus.w_state_o), 32'd0);
        chk("rstw_stall", 32'(bus.w_stall_req_o), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("rstw_no_write", 32'(bus.rf_rd_write_o), 32'd0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0, 1: tx_load(3'($urandom), $urandom, $urandom, 5'($urandom), $urandom_range(0, 3));
                2:    tx_store($urandom_range(0, 3));
                default: begin
                    if ($urandom_range(0, 1) == 0) tx_alu(5'($urandom), $urandom);
                    else tx_stray_done();
                end
            endcase
        end

        @(negedge clk);
        #1;
        chk("final_state", 32'(bus.w_state_o), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
